lsu_arbiter: RTL and testbench

Shares the single LSU data port between two requesters: port 0 is the core load/store stage, and port 1 is a debug/DMA master. Each accepted request becomes exactly one LSU access of one cycle. The block captures the load result and returns it with a one-cycle acknowledge. Arbitration between the two ports is round-robin.

---
 rtl/lsu_arbiter_if.sv | 62 ++++++
 rtl/lsu_arbiter.sv | 122 ++++++++++++
 tb/tb_lsu_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_arbiter_if.sv
// Bus bundle for lsu_arbiter: two requester ports, the LSU data port and status.
// Lock inputs exist only when LSU_ARB_LOCK_EN is defined.
interface lsu_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              i_req0;
  logic              i_wren0;
  logic [2:0]        i_funct3_0;
  logic [ADDR_W-1:0] i_addr0;
  logic [DATA_W-1:0] i_wdata0;
  logic              o_ack0;
  logic [DATA_W-1:0] o_rdata0;

  logic              i_req1;
  logic              i_wren1;
  logic [2:0]        i_funct3_1;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_ack1;
  logic [DATA_W-1:0] o_rdata1;

  logic [ADDR_W-1:0] o_lsu_addr;
  logic              o_lsu_wren;
  logic [2:0]        o_lsu_funct3;
  logic [DATA_W-1:0] o_lsu_st_data;
  logic [DATA_W-1:0] i_lsu_ld_data;

  logic              o_busy;
  logic              o_grant_id;

`ifdef LSU_ARB_LOCK_EN
  logic              i_lock0;
  logic              i_lock1;
`endif

  modport slave (
`ifdef LSU_ARB_LOCK_EN
    input  i_lock0, i_lock1,
`endif
    input  i_req0, i_wren0, i_funct3_0, i_addr0, i_wdata0,
    output o_ack0, o_rdata0,
    input  i_req1, i_wren1, i_funct3_1, i_addr1, i_wdata1,
    output o_ack1, o_rdata1,
    output o_lsu_addr, o_lsu_wren, o_lsu_funct3, o_lsu_st_data,
    input  i_lsu_ld_data,
    output o_busy, o_grant_id
  );

  modport master (
`ifdef LSU_ARB_LOCK_EN
    output i_lock0, i_lock1,
`endif
    output i_req0, i_wren0, i_funct3_0, i_addr0, i_wdata0,
    input  o_ack0, o_rdata0,
    output i_req1, i_wren1, i_funct3_1, i_addr1, i_wdata1,
    input  o_ack1, o_rdata1,
    input  o_lsu_addr, o_lsu_wren, o_lsu_funct3, o_lsu_st_data,
    output i_lsu_ld_data,
    input  o_busy, o_grant_id
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one LSU data port between the core (port 0) and a
// debug/DMA master (port 1). Optional grant locking under LSU_ARB_LOCK_EN.
module lsu_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lsu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q;
  logic              last_q;
  logic              grant_q;
  logic              cmd_wren_q;
  logic [2:0]        cmd_funct3_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic [ADDR_W-1:0] lsu_addr_q;
  logic              lsu_wren_q;
  logic              busy_q;
  logic              ack0_q;
  logic              ack1_q;
  logic              lock_q;

  logic              any_req;
  logic              winner_d;
  logic              locked_req;
  logic              served_lock;

  always_comb begin
    any_req    = bus.i_req0 | bus.i_req1;
    locked_req = grant_q ? bus.i_req1 : bus.i_req0;
`ifdef LSU_ARB_LOCK_EN
    served_lock = grant_q ? bus.i_lock1 : bus.i_lock0;
`else
    served_lock = 1'b0;
`endif
    winner_d = (bus.i_req0 & bus.i_req1) ? ~last_q : bus.i_req1;
    // A held lock overrides round-robin as long as the locked port keeps asking.
    if (lock_q && locked_req) begin
      winner_d = grant_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      grant_q      <= 1'b0;
      cmd_wren_q   <= 1'b0;
      cmd_funct3_q <= '0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      resp_q       <= '0;
      lsu_addr_q   <= '0;
      lsu_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lock_q && !locked_req) begin
            lock_q <= 1'b0;
          end
          if (any_req) begin
            grant_q    <= winner_d;
            lsu_addr_q <= winner_d ? bus.i_addr1 : bus.i_addr0;
            lsu_wren_q <= winner_d ? bus.i_wren1 : bus.i_wren0;
            cmd_wren_q   <= winner_d ? bus.i_wren1    : bus.i_wren0;
            cmd_funct3_q <= winner_d ? bus.i_funct3_1 : bus.i_funct3_0;
            cmd_addr_q   <= winner_d ? bus.i_addr1    : bus.i_addr0;
            cmd_wdata_q  <= winner_d ? bus.i_wdata1   : bus.i_wdata0;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          resp_q     <= bus.i_lsu_ld_data;
          if (!lock_q) begin
            last_q <= grant_q;
          end
          lsu_addr_q <= '0;
          lsu_wren_q <= 1'b0;
          ack0_q     <= ~grant_q;
          ack1_q     <= grant_q;
          state_q    <= RESP;
        end
        RESP: begin
          lock_q  <= served_lock;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_lsu_addr    = lsu_addr_q;
  assign bus.o_lsu_wren    = lsu_wren_q;
  assign bus.o_lsu_funct3  = cmd_funct3_q;
  assign bus.o_lsu_st_data = cmd_wdata_q;
  assign bus.o_ack0        = ack0_q;
  assign bus.o_ack1        = ack1_q;
  assign bus.o_rdata0      = ack0_q ? resp_q : '0;
  assign bus.o_rdata1      = ack1_q ? resp_q : '0;
  assign bus.o_busy        = busy_q;
  assign bus.o_grant_id    = grant_q;

  logic unused_ok;
  assign unused_ok = cmd_wren_q ^ cmd_addr_q[0];

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: per-cycle vector table plus hand-written
// sequences for request drop after grant and reset during an access.
module tb_lsu_arbiter;

  logic i_clk;
  logic i_rst_n;

  lsu_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        req0;
    logic        wren0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        wren1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic [31:0] ld;
    logic        ack0;
    logic [31:0] rdata0;
    logic        ack1;
    logic [31:0] rdata1;
    logic [31:0] lsu_addr;
    logic        lsu_wren;
    logic [31:0] st_data;
    logic        busy;
    logic        grant;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic [31:0] ld,
    input logic k0, input logic [31:0] rd0, input logic k1, input logic [31:0] rd1,
    input logic [31:0] la, input logic lw, input logic [31:0] st,
    input logic bz, input logic g);
    vec_t v;
    v.req0 = r0; v.wren0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.wren1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.ld = ld;
    v.ack0 = k0; v.rdata0 = rd0; v.ack1 = k1; v.rdata1 = rd1;
    v.lsu_addr = la; v.lsu_wren = lw; v.st_data = st;
    v.busy = bz; v.grant = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    bus.i_req0 = 1'b0; bus.i_wren0 = 1'b0; bus.i_funct3_0 = 3'b010;
    bus.i_addr0 = '0; bus.i_wdata0 = '0;
    bus.i_req1 = 1'b0; bus.i_wren1 = 1'b0; bus.i_funct3_1 = 3'b010;
    bus.i_addr1 = '0; bus.i_wdata1 = '0;
    bus.i_lsu_ld_data = '0;
  endtask

`ifdef LSU_ARB_LOCK_EN
  initial begin
    bus.i_lock0 = 1'b0;
    bus.i_lock1 = 1'b0;
  end
`endif

  localparam logic [31:0] A0 = 32'hA0A0A0A0;
  localparam logic [31:0] B1 = 32'hB1B1B1B1;

  vec_t vecs[18];

  initial begin
    // Per-row: inputs held across one rising edge, outputs checked at the next falling edge.
    vecs[0]  = mk(1,0,32'h2004,0, 0,0,0,0, 0,            0,0,0,0, 32'h2004,0,0,          1,0);
    vecs[1]  = mk(1,0,32'h2004,0, 0,0,0,0, 32'hDEADBEEF, 1,32'hDEADBEEF,0,0, 0,0,0,     1,0);
    vecs[2]  = mk(0,0,0,0,        0,0,0,0, 0,            0,0,0,0, 0,0,0,                0,0);
    vecs[3]  = mk(0,0,0,0, 1,1,32'h7000,32'h12345678, 0, 0,0,0,0, 32'h7000,1,32'h12345678, 1,1);
    vecs[4]  = mk(0,0,0,0, 1,1,32'h7000,32'h12345678, 32'hAAAA5555, 0,0,1,32'hAAAA5555, 0,0,32'h12345678, 1,1);
    vecs[5]  = mk(0,0,0,0, 0,0,0,0, 0,               0,0,0,0, 0,0,32'h12345678,       0,1);
    vecs[6]  = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 32'h100,0,A0,  1,0);
    vecs[7]  = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 32'h11, 1,32'h11,0,0, 0,0,A0, 1,0);
    vecs[8]  = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 0,0,A0,        0,0);
    vecs[9]  = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 32'h200,0,B1,  1,1);
    vecs[10] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 32'h22, 0,0,1,32'h22, 0,0,B1, 1,1);
    vecs[11] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 0,0,B1,        0,1);
    vecs[12] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 32'h100,0,A0,  1,0);
    vecs[13] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 32'h33, 1,32'h33,0,0, 0,0,A0, 1,0);
    vecs[14] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 0,0,A0,        0,0);
    vecs[15] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 0,     0,0,0,0, 32'h200,0,B1,  1,1);
    vecs[16] = mk(1,0,32'h100,A0, 1,0,32'h200,B1, 32'h44, 0,0,1,32'h44, 0,0,B1, 1,1);
    vecs[17] = mk(0,0,0,0, 0,0,0,0, 0,                0,0,0,0, 0,0,B1,        0,1);

    idle_inputs();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_ack0",   32'(bus.o_ack0), 0);
    chk("rst_ack1",   32'(bus.o_ack1), 0);
    chk("rst_rdata0", bus.o_rdata0, 0);
    chk("rst_rdata1", bus.o_rdata1, 0);
    chk("rst_laddr",  bus.o_lsu_addr, 0);
    chk("rst_lwren",  32'(bus.o_lsu_wren), 0);
    chk("rst_lf3",    32'(bus.o_lsu_funct3), 0);
    chk("rst_lst",    bus.o_lsu_st_data, 0);
    chk("rst_busy",   32'(bus.o_busy), 0);
    chk("rst_grant",  32'(bus.o_grant_id), 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int unsigned i = 0; i < 18; i++) begin
      bus.i_req0 = vecs[i].req0; bus.i_wren0 = vecs[i].wren0;
      bus.i_addr0 = vecs[i].addr0; bus.i_wdata0 = vecs[i].wdata0;
      bus.i_req1 = vecs[i].req1; bus.i_wren1 = vecs[i].wren1;
      bus.i_addr1 = vecs[i].addr1; bus.i_wdata1 = vecs[i].wdata1;
      bus.i_lsu_ld_data = vecs[i].ld;
      tick();
      chk($sformatf("v%0d_ack0", i),   32'(bus.o_ack0),     32'(vecs[i].ack0));
      chk($sformatf("v%0d_rdata0", i), bus.o_rdata0,        vecs[i].rdata0);
      chk($sformatf("v%0d_ack1", i),   32'(bus.o_ack1),     32'(vecs[i].ack1));
      chk($sformatf("v%0d_rdata1", i), bus.o_rdata1,        vecs[i].rdata1);
      chk($sformatf("v%0d_laddr", i),  bus.o_lsu_addr,      vecs[i].lsu_addr);
      chk($sformatf("v%0d_lwren", i),  32'(bus.o_lsu_wren), 32'(vecs[i].lsu_wren));
      chk($sformatf("v%0d_lst", i),    bus.o_lsu_st_data,   vecs[i].st_data);
      chk($sformatf("v%0d_busy", i),   32'(bus.o_busy),     32'(vecs[i].busy));
      chk($sformatf("v%0d_grant", i),  32'(bus.o_grant_id), 32'(vecs[i].grant));
    end

    // Port 0 drops req right after its grant: access still completes, nothing reissued.
    idle_inputs();
    bus.i_req0 = 1'b1; bus.i_addr0 = 32'h40; bus.i_lsu_ld_data = 32'h5A;
    tick();
    chk("drop_grant", 32'(bus.o_grant_id), 0);
    chk("drop_laddr", bus.o_lsu_addr, 32'h40);
    bus.i_req0 = 1'b0;
    tick();
    chk("drop_ack0",   32'(bus.o_ack0), 1);
    chk("drop_rdata0", bus.o_rdata0, 32'h5A);
    tick();
    chk("drop_idle_busy", 32'(bus.o_busy), 0);
    tick();
    chk("drop_no2_busy",  32'(bus.o_busy), 0);
    chk("drop_no2_laddr", bus.o_lsu_addr, 0);
    chk("drop_no2_ack0",  32'(bus.o_ack0), 0);

    // Reset during an SB access, then check port 0 wins the first tie afterwards.
    bus.i_req1 = 1'b1; bus.i_wren1 = 1'b1; bus.i_funct3_1 = 3'b000;
    bus.i_addr1 = 32'h30; bus.i_wdata1 = 32'hFF;
    tick();
    chk("sb_lwren", 32'(bus.o_lsu_wren), 1);
    chk("sb_laddr", bus.o_lsu_addr, 32'h30);
    chk("sb_lf3",   32'(bus.o_lsu_funct3), 0);
    chk("sb_lst",   bus.o_lsu_st_data, 32'hFF);
    chk("sb_grant", 32'(bus.o_grant_id), 1);
    bus.i_req0 = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rmid_lwren", 32'(bus.o_lsu_wren), 0);
    chk("rmid_busy",  32'(bus.o_busy), 0);
    chk("rmid_ack0",  32'(bus.o_ack0), 0);
    chk("rmid_ack1",  32'(bus.o_ack1), 0);
    chk("rmid_laddr", bus.o_lsu_addr, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chk("post_grant", 32'(bus.o_grant_id), 0);
    chk("post_laddr", bus.o_lsu_addr, 32'h40);
    chk("post_lwren", 32'(bus.o_lsu_wren), 0);
    bus.i_lsu_ld_data = 32'h77;
    tick();
    chk("post_ack0",   32'(bus.o_ack0), 1);
    chk("post_rdata0", bus.o_rdata0, 32'h77);
    chk("post_ack1",   32'(bus.o_ack1), 0);
    idle_inputs();
    tick();
    chk("post_busy", 32'(bus.o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
